// File: rtl/ram_pkg.sv
// ram_pkg: shared types and widths for the RAM command master
package ram_pkg;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DIN_W  = 10;
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } ram_cmd_t;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RESP} master_state_t;
endpackage

// File: rtl/ram_rd_timer.sv
// ram_rd_timer: read-wait counter; clr zeroes it, inc counts, expired when count == MAX-1
// Ports: clk, rst (sync, active-high), clr, inc, expired
module ram_rd_timer #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 8'd1;
    assign expired = cnt == 8'(MAX - 1);
endmodule

// File: rtl/ram_cmd_master.sv
// ram_cmd_master: issues two-word RAM commands per request and returns a held response
// Ports: req_* request handshake (valid/ready, wr, addr, wdata); rsp_* response handshake
// (valid/ready, data, err); ram_din/ram_rx_valid command words to the RAM; ram_dout/ram_tx_valid
// read data from the RAM. All outputs are registered. Define RAM_MASTER_TIMEOUT_EN to build
// the TIMEOUT-cycle read timeout; otherwise reads wait forever and rsp_err stays 0.
module ram_cmd_master
    import ram_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [RAM_DATA_W-1:0] req_addr,
    input  logic [RAM_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RAM_DATA_W-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [RAM_DIN_W-1:0]  ram_din,
    output logic                  ram_rx_valid,
    input  logic [RAM_DATA_W-1:0] ram_dout,
    input  logic                  ram_tx_valid
);
    master_state_t state, nxt;
    logic wr_q;
    logic [RAM_DATA_W-1:0] addr_q, wdata_q, d_data;
    logic [RAM_DIN_W-1:0] d_din;
    logic d_rxv, d_err, expired;
`ifdef RAM_MASTER_TIMEOUT_EN
    ram_rd_timer #(.MAX(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state == DATA),
        .inc(state == WAIT_RD),
        .expired(expired)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif
    // Outputs are registered from the values they must carry in the next state, so the
    // address word appears the cycle after acceptance.
    always_comb begin
        nxt = state;
        d_din = '0;
        d_rxv = 1'b0;
        d_data = '0;
        d_err = 1'b0;
        case (state)
            IDLE:
                if (req_valid && req_ready) begin
                    nxt = ADDR;
                    d_din = {req_wr ? CMD_WR_ADDR : CMD_RD_ADDR, req_addr};
                    d_rxv = 1'b1;
                end
            ADDR: begin
                nxt = DATA;
                d_din = {wr_q ? CMD_WR_DATA : CMD_RD_DATA, wr_q ? wdata_q : 8'h00};
                d_rxv = 1'b1;
            end
            DATA: nxt = wr_q ? RESP : WAIT_RD;
            WAIT_RD:
                if (ram_tx_valid) begin
                    nxt = RESP;
                    d_data = ram_dout;
                end else if (expired) begin
                    nxt = RESP;
                    d_err = 1'b1;
                end
            RESP: begin
                nxt = rsp_ready ? IDLE : RESP;
                d_data = rsp_ready ? '0 : rsp_data;
                d_err = rsp_ready ? 1'b0 : rsp_err;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            ram_din <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            state <= nxt;
            req_ready <= nxt == IDLE;
            rsp_valid <= nxt == RESP;
            rsp_data <= d_data;
            rsp_err <= d_err;
            ram_din <= d_din;
            ram_rx_valid <= d_rxv;
        end
    always_ff @(posedge clk)
        if (state == IDLE && req_valid && req_ready) begin
            wr_q <= req_wr;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
        end
endmodule

// File: tb/tb_ram_cmd_master.sv
// tb_ram_cmd_master: directed and random requests against a transaction-level RAM model
module tb_ram_cmd_master;
    localparam int TO = 16;
`ifdef RAM_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, req_wr = 0;
    logic [7:0] req_addr = 0, req_wdata = 0;
    logic rsp_valid, rsp_ready = 0, rsp_err;
    logic [7:0] rsp_data, ram_dout = 0;
    logic [9:0] ram_din;
    logic ram_rx_valid, ram_tx_valid = 0;
    int total = 0, bad = 0;
    logic [7:0] mem [256];

    ram_cmd_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rc: cycle (counted from acceptance) in which the RAM answers a read
    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input int rc, input int hold, input bit pend);
        int rcyc;
        logic [7:0] exp_d;
        bit exp_e;
        for (int i = 0; i < 10 && !req_ready; i++) tick();
        chk("ready_before_req", req_ready, 1);
        req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
        ram_tx_valid = 1'($urandom); ram_dout = 8'($urandom);
        tick();
        req_valid = 0; req_wr = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
        chk("c1_rx_valid", ram_rx_valid, 1);
        chk("c1_addr_word", ram_din, {wr ? 2'b00 : 2'b10, a});
        chk("c1_req_ready", req_ready, 0);
        ram_tx_valid = 1'($urandom);
        tick();
        chk("c2_rx_valid", ram_rx_valid, 1);
        chk("c2_data_word", ram_din, {wr ? 2'b01 : 2'b11, wr ? d : 8'h00});
        if (wr) begin
            mem[a] = d;
            rcyc = 3; exp_d = 8'h00; exp_e = 0;
        end else begin
            exp_e = TO_EN && !(rc >= 3 && rc < 3 + TO);
            rcyc = exp_e ? 3 + TO : rc + 1;
            exp_d = exp_e ? 8'h00 : mem[a];
        end
        for (int c = 3; c < rcyc; c++) begin
            tick();
            chk("wait_no_rsp", rsp_valid, 0);
            chk("wait_no_rx", ram_rx_valid, 0);
            ram_tx_valid = c == rc;
            ram_dout = c == rc ? mem[a] : 8'($urandom);
        end
        tick();
        ram_tx_valid = 1'($urandom); ram_dout = 8'($urandom);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", rsp_err, exp_e);
        for (int h = 0; h < hold; h++) begin
            if (pend) begin req_valid = 1; req_wr = 1; end
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp_d);
            chk("hold_err", rsp_err, exp_e);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_no_rx", ram_rx_valid, 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0; req_valid = 0; ram_tx_valid = 0;
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_req_ready", req_ready, 1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_rx_valid", ram_rx_valid, 0);
        rst = 0;
        tick();
        chk("post_rst_ready", req_ready, 1);

        do_req(1, 8'h3C, 8'hA5, 0, 0, 0);
        do_req(0, 8'h3C, 8'h00, 3, 0, 0);
        if (TO_EN) do_req(0, 8'h11, 8'h00, 1000, 0, 0);
        else do_req(0, 8'h11, 8'h00, 3 + TO + 4, 0, 0);
        do_req(0, 8'h3C, 8'h00, 4, 5, 1);

        // reset in the middle of a write
        req_valid = 1; req_wr = 1; req_addr = 8'h55; req_wdata = 8'h66;
        tick();
        req_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_rx_valid", ram_rx_valid, 0);
        chk("mid_rst_ram_din", ram_din, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        tick();
        chk("mid_rst_ready", req_ready, 1);
        seen = 0;
        rsp_ready = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= rsp_valid | ram_rx_valid;
        end
        rsp_ready = 0;
        chk("abandoned_no_rsp", seen, 0);

        // stale pulse in IDLE, then a read answered at cycle 5
        ram_tx_valid = 1; ram_dout = 8'hEE;
        tick();
        ram_tx_valid = 0;
        mem[8'h42] = 8'h17;
        do_req(0, 8'h42, 8'h00, 5, 0, 0);

        for (int n = 0; n < 25; n++) begin
            int rc;
            rc = TO_EN ? 3 + int'($urandom_range(0, TO + 2)) : 3 + int'($urandom_range(0, 6));
            do_req(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), rc,
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
